// File: rtl/alu_issue.sv
// Decode-and-issue stage for a combinational RV64 ALU: accepts one instruction,
// drives registered ALU inputs, captures the result and writes back to the register file.
module alu_issue #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic [10:0]     alu_opcode,
  output logic [XLEN-1:0] alu_value1,
  output logic [XLEN-1:0] alu_value2,
  output logic [31:0]     alu_immediate,
  output logic [5:0]      alu_shamt,
  input  logic [XLEN-1:0] alu_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_data,
  output logic            out_illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam logic [10:0] OP_NOTHING  = 11'd0;
  localparam logic [10:0] OP_ADD      = 11'd1;
  localparam logic [10:0] OP_SUB      = 11'd2;
  localparam logic [10:0] OP_MUL      = 11'd3;
  localparam logic [10:0] OP_DIV      = 11'd4;
  localparam logic [10:0] OP_XOR      = 11'd5;
  localparam logic [10:0] OP_AND      = 11'd6;
  localparam logic [10:0] OP_OR       = 11'd7;
  localparam logic [10:0] OP_REM      = 11'd8;
  localparam logic [10:0] OP_LOGLEFT  = 11'd9;
  localparam logic [10:0] OP_LOGRIGHT = 11'd10;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t state, state_next;

  logic [XLEN-1:0] regs [NREGS];

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [XLEN-1:0] rs1_val, rs2_val;

  logic [10:0] dec_op;
  logic [31:0] dec_imm;
  logic [5:0]  dec_shamt;
  logic        dec_use_rs2;
  logic        dec_illegal;

  logic [4:0]  rd_q;
  logic        illegal_q;
  logic        div_zero_q;
  logic [XLEN-1:0] result_sel;

  assign opc = in_instr[6:0];
  assign rd  = in_instr[11:7];
  assign f3  = in_instr[14:12];
  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];
  assign f7  = in_instr[31:25];

  assign rs1_val  = (rs1 == '0) ? '0 : regs[rs1];
  assign rs2_val  = (rs2 == '0) ? '0 : regs[rs2];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

  always_comb begin
    dec_op      = OP_NOTHING;
    dec_imm     = '0;
    dec_shamt   = '0;
    dec_use_rs2 = 1'b0;
    dec_illegal = 1'b1;
    if (opc == OPC_R) begin
      dec_use_rs2 = 1'b1;
      dec_illegal = 1'b0;
      if (f7 == 7'b0000000) begin
        case (f3)
          3'b000:  dec_op = OP_ADD;
          3'b100:  dec_op = OP_XOR;
          3'b110:  dec_op = OP_OR;
          3'b111:  dec_op = OP_AND;
          3'b001:  dec_op = OP_LOGLEFT;
          3'b101:  dec_op = OP_LOGRIGHT;
          default: dec_illegal = 1'b1;
        endcase
      end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
        dec_op = OP_SUB;
      end else if (f7 == 7'b0000001) begin
        case (f3)
          3'b000:  dec_op = OP_MUL;
          3'b100:  dec_op = OP_DIV;
          3'b110:  dec_op = OP_REM;
          default: dec_illegal = 1'b1;
        endcase
      end else begin
        dec_illegal = 1'b1;
      end
      // Register shifts take their amount from rs2; the alu ignores value2 for shifts
      if (dec_op == OP_LOGLEFT || dec_op == OP_LOGRIGHT)
        dec_shamt = rs2_val[5:0];
    end else if (opc == OPC_I) begin
      dec_illegal = 1'b0;
      dec_imm     = {{20{in_instr[31]}}, in_instr[31:20]};
      case (f3)
        3'b000: dec_op = OP_ADD;
        3'b100: dec_op = OP_XOR;
        3'b110: dec_op = OP_OR;
        3'b111: dec_op = OP_AND;
        3'b001, 3'b101: begin
          dec_imm     = '0;
          dec_shamt   = in_instr[25:20];
          dec_op      = (f3 == 3'b001) ? OP_LOGLEFT : OP_LOGRIGHT;
          dec_illegal = (in_instr[31:26] != 6'b000000);
        end
        default: dec_illegal = 1'b1;
      endcase
    end
    if (dec_illegal) begin
      dec_op      = OP_NOTHING;
      dec_imm     = '0;
      dec_shamt   = '0;
      dec_use_rs2 = 1'b0;
    end
  end

  // Divide-by-zero results are produced here rather than trusted from the alu
  always_comb begin
    result_sel = alu_result;
    if (illegal_q)
      result_sel = '0;
    else if (div_zero_q)
      result_sel = (alu_opcode == OP_DIV) ? '1 : alu_value1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = EXEC;
      EXEC:    state_next = WB;
      WB:      if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == WB);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_opcode    <= OP_NOTHING;
      alu_value1    <= '0;
      alu_value2    <= '0;
      alu_immediate <= '0;
      alu_shamt     <= '0;
      rd_q          <= '0;
      illegal_q     <= 1'b0;
      div_zero_q    <= 1'b0;
      out_rd        <= '0;
      out_data      <= '0;
      out_illegal   <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          alu_opcode    <= dec_op;
          alu_value1    <= dec_illegal ? '0 : rs1_val;
          alu_value2    <= dec_use_rs2 ? rs2_val : '0;
          alu_immediate <= dec_imm;
          alu_shamt     <= dec_shamt;
          rd_q          <= rd;
          illegal_q     <= dec_illegal;
          div_zero_q    <= (dec_op == OP_DIV || dec_op == OP_REM) && (rs2_val == '0);
        end
        EXEC: begin
          out_rd      <= rd_q;
          out_data    <= result_sel;
          out_illegal <= illegal_q;
          if (!illegal_q && rd_q != '0) regs[rd_q] <= result_sel;
        end
        WB: if (out_ready) begin
          alu_opcode    <= OP_NOTHING;
          alu_value1    <= '0;
          alu_value2    <= '0;
          alu_immediate <= '0;
          alu_shamt     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural combinational alu attached.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [10:0] alu_opcode;
  logic [63:0] alu_value1, alu_value2;
  logic [31:0] alu_immediate;
  logic [5:0]  alu_shamt;
  logic [63:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [63:0] out_data;
  logic        out_illegal;
  logic [4:0]  dbg_addr;
  logic [63:0] dbg_data;

  int checks = 0;
  int errors = 0;

  alu_issue dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .alu_opcode(alu_opcode), .alu_value1(alu_value1), .alu_value2(alu_value2),
    .alu_immediate(alu_immediate), .alu_shamt(alu_shamt), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_data(out_data), .out_illegal(out_illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Stand-in for the downstream alu: immediate wins when nonzero, else value2
  logic [63:0] op2;
  always_comb begin
    op2 = (alu_immediate != 32'd0) ? {{32{alu_immediate[31]}}, alu_immediate} : alu_value2;
    alu_result = 64'd0;
    case (alu_opcode)
      11'd1:  alu_result = alu_value1 + op2;
      11'd2:  alu_result = alu_value1 - op2;
      11'd3:  alu_result = alu_value1 * op2;
      11'd4:  alu_result = (op2 == 64'd0) ? 64'd0 : 64'($signed(alu_value1) / $signed(op2));
      11'd5:  alu_result = alu_value1 ^ op2;
      11'd6:  alu_result = alu_value1 & op2;
      11'd7:  alu_result = alu_value1 | op2;
      11'd8:  alu_result = (op2 == 64'd0) ? 64'd0 : 64'($signed(alu_value1) % $signed(op2));
      11'd9:  alu_result = alu_value1 << alu_shamt;
      11'd10: alu_result = alu_value1 >> alu_shamt;
      default: alu_result = 64'd0;
    endcase
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Offers one instruction and returns #1 after the accept edge (block in EXEC)
  task automatic applyStimulus(input logic [31:0] instr);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("in_ready_wait", in_ready, 1'b1);
    in_valid = 1'b1;
    in_instr = instr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_instr = 32'd0;
  endtask

  task automatic finishInstr(input string tag, input logic [10:0] op_exp, input logic [4:0] rd_exp,
                             input logic [63:0] data_exp, input logic ill_exp);
    checkOutput({tag, "_opcode"}, alu_opcode, op_exp);
    checkOutput({tag, "_exec_valid"}, out_valid, 1'b0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_wb_valid"}, out_valid, 1'b1);
    checkOutput({tag, "_data"}, out_data, data_exp);
    checkOutput({tag, "_rd"}, out_rd, rd_exp);
    checkOutput({tag, "_illegal"}, out_illegal, ill_exp);
    @(posedge clk);
    #1;
    checkOutput({tag, "_idle_ready"}, in_ready, 1'b1);
    checkOutput({tag, "_idle_op"}, alu_opcode, 11'd0);
  endtask

  task automatic checkReg(input string tag, input logic [4:0] addr, input logic [63:0] expected);
    dbg_addr = addr;
    #1;
    checkOutput(tag, dbg_data, expected);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b1; dbg_addr = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) checkReg("reset_reg", 5'(i), 64'd0);
    checkOutput("reset_in_ready", in_ready, 1'b1);
    checkOutput("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_opcode", alu_opcode, 11'd0);
    checkOutput("reset_out_data", out_data, 64'd0);

    applyStimulus(enc_i(12'hFFB, 5'd0, 3'b000, 5'd1));
    checkOutput("addi_imm", alu_immediate, 32'hFFFF_FFFB);
    finishInstr("addi_x1", 11'd1, 5'd1, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0);
    applyStimulus(enc_i(12'd7, 5'd0, 3'b000, 5'd2));
    finishInstr("addi_x2", 11'd1, 5'd2, 64'd7, 1'b0);

    applyStimulus(enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3));
    checkOutput("add_imm", alu_immediate, 32'd0);
    checkOutput("add_v1", alu_value1, 64'hFFFF_FFFF_FFFF_FFFB);
    checkOutput("add_v2", alu_value2, 64'd7);
    finishInstr("add_x3", 11'd1, 5'd3, 64'd2, 1'b0);
    checkReg("x3", 5'd3, 64'd2);

    applyStimulus(enc_i(12'd3, 5'd2, 3'b001, 5'd4));
    checkOutput("slli_imm", alu_immediate, 32'd0);
    checkOutput("slli_shamt", alu_shamt, 6'd3);
    finishInstr("slli_x4", 11'd9, 5'd4, 64'd56, 1'b0);
    checkReg("x4", 5'd4, 64'd56);

    applyStimulus(enc_r(7'b0000000, 5'd2, 5'd2, 3'b001, 5'd5));
    checkOutput("sll_shamt", alu_shamt, 6'd7);
    checkOutput("sll_v2", alu_value2, 64'd7);
    finishInstr("sll_x5", 11'd9, 5'd5, 64'd896, 1'b0);
    checkReg("x5", 5'd5, 64'd896);

    applyStimulus(enc_i(12'd0, 5'd2, 3'b000, 5'd6));
    checkOutput("addi0_v2", alu_value2, 64'd0);
    finishInstr("addi0_x6", 11'd1, 5'd6, 64'd7, 1'b0);

    applyStimulus(enc_r(7'b0000001, 5'd0, 5'd2, 3'b100, 5'd7));
    finishInstr("div0_x7", 11'd4, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    checkReg("x7", 5'd7, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(enc_r(7'b0000001, 5'd0, 5'd2, 3'b110, 5'd8));
    finishInstr("rem0_x8", 11'd8, 5'd8, 64'd7, 1'b0);
    checkReg("x8", 5'd8, 64'd7);
    applyStimulus(enc_r(7'b0000001, 5'd2, 5'd1, 3'b100, 5'd9));
    finishInstr("div_x9", 11'd4, 5'd9, 64'd0, 1'b0);

    applyStimulus(enc_r(7'b0100000, 5'd1, 5'd2, 3'b000, 5'd13));
    finishInstr("sub_x13", 11'd2, 5'd13, 64'd12, 1'b0);
    applyStimulus(enc_i(12'h0F0, 5'd1, 3'b111, 5'd14));
    finishInstr("andi_x14", 11'd6, 5'd14, 64'h0000_0000_0000_00F0, 1'b0);
    applyStimulus(enc_i(12'hFFF, 5'd0, 3'b110, 5'd15));
    checkOutput("ori_imm", alu_immediate, 32'hFFFF_FFFF);
    finishInstr("ori_x15", 11'd7, 5'd15, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

    applyStimulus(enc_r(7'b0100000, 5'd2, 5'd2, 3'b101, 5'd11));
    finishInstr("sra_ill", 11'd0, 5'd11, 64'd0, 1'b1);
    checkReg("x11", 5'd11, 64'd0);
    applyStimulus({20'h12345, 5'd12, 7'b0110111});
    finishInstr("lui_ill", 11'd0, 5'd12, 64'd0, 1'b1);
    checkReg("x12", 5'd12, 64'd0);

    applyStimulus(enc_r(7'b0000000, 5'd2, 5'd2, 3'b000, 5'd0));
    finishInstr("add_x0", 11'd1, 5'd0, 64'd14, 1'b0);
    checkReg("x0", 5'd0, 64'd0);

    // Consumer stall in WB
    out_ready = 1'b0;
    applyStimulus(enc_r(7'b0000000, 5'd2, 5'd2, 3'b000, 5'd16));
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", out_valid, 1'b1);
      checkOutput("stall_data", out_data, 64'd14);
      checkOutput("stall_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("stall_release_ready", in_ready, 1'b1);
    checkOutput("stall_release_valid", out_valid, 1'b0);
    checkReg("x16", 5'd16, 64'd14);

    // Reset while in EXEC drops the instruction
    applyStimulus(enc_i(12'd5, 5'd2, 3'b000, 5'd17));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rst_exec_ready", in_ready, 1'b1);
    checkOutput("rst_exec_valid", out_valid, 1'b0);
    checkOutput("rst_exec_op", alu_opcode, 11'd0);
    checkReg("x17", 5'd17, 64'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_exec_still_idle", out_valid, 1'b0);
    checkReg("x17_later", 5'd17, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
